i2c_cfg_arbiter: RTL

- Shares one i2c_com engine (the SCCB master) between two camera register-configuration sequencers, one per lens of the dual-camera module.
- Grants the bus to one requester at a time using round-robin.
- Drives start/i2c_data to the engine, supervises tr_end with a timeout, retries on NACK, and returns per-requester done/error.
- Sits between the two per-camera config sequencers and the single i2c_com instance. Runs on the I2C control clock (20 kHz).

---
 rtl/i2c_cfg_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 19 +
 rtl/i2c_cfg_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the dual-camera SCCB configuration arbiter.
package i2c_cfg_pkg;
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_END = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  localparam logic [7:0] DEV_OV5640 = 8'h78;

  // Layout of the 32-bit write word: {dev_addr, reg_addr, value}
  localparam int DEV_MSB = 31;
  localparam int DEV_LSB = 24;
  localparam int REG_MSB = 23;
  localparam int REG_LSB = 8;
  localparam int VAL_MSB = 7;
  localparam int VAL_LSB = 0;

  localparam int TO_W = 10;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; on a tie the requester that did not win last time wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_vld,
  output logic       gnt_sel,
  output logic       last
);
  assign gnt_vld = |req;
  assign gnt_sel = (req == 2'b11) ? ~last : req[1];

  // Resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last <= 1'b1;
    else if (take) last <= gnt_sel;
  end
endmodule

// File: rtl/i2c_cfg_arbiter.sv
// Shares one i2c_com write engine between two camera config sequencers:
// round-robin grant, tr_end timeout, retry on NACK, per-requester done/err.
module i2c_cfg_arbiter
  import i2c_cfg_pkg::*;
#(
  parameter int NUM_RETRY   = 2,
  parameter int TIMEOUT_CYC = 1023,
  parameter int GAP_CYC     = 2
) (
  input  logic        clock_i2c,
  input  logic        camera_rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] i2c_data0,
  input  logic [31:0] i2c_data1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic        busy,
  output logic        gnt_id,
  output logic        start,
  output logic [31:0] i2c_data,
  input  logic        tr_end,
  input  logic        ack
);
  localparam logic [2:0]      RETRY_MAX = 3'(NUM_RETRY);
  localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT_CYC);
  localparam logic [3:0]      GAP_LAST  = 4'(GAP_CYC - 1);

  state_t          state, state_nxt;
  logic [2:0]      retry_cnt;
  logic [TO_W-1:0] to_cnt, to_inc;
  logic [3:0]      gap_cnt;
  logic            retry_pend, done_q, err_q;
  logic [1:0]      mask;
  logic            gnt_vld, gnt_sel, take, fin, fin_err, retry;

  assign to_inc = to_cnt + 1'b1;

  // The granted requester stays masked until one cycle after its done,
  // so a req that is still high from the finished write cannot re-grant.
  rr_arb2 u_arb (
    .clk     (clock_i2c),
    .rst     (camera_rst),
    .req     ({req1, req0} & ~mask),
    .take    (take),
    .gnt_vld (gnt_vld),
    .gnt_sel (gnt_sel),
    .last    (gnt_id)
  );

  always_ff @(posedge clock_i2c or posedge camera_rst) begin
    if (camera_rst) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    fin       = 1'b0;
    fin_err   = 1'b0;
    retry     = 1'b0;
    case (state)
      S_IDLE: if (gnt_vld) begin
        take      = 1'b1;
        state_nxt = S_ISSUE;
      end
      S_ISSUE: state_nxt = S_WAIT_END;
      S_WAIT_END: begin
        // tr_end takes priority over a timeout landing in the same cycle
        if (tr_end) begin
          state_nxt = S_GAP;
          if (ack)                         fin   = 1'b1;
          else if (retry_cnt < RETRY_MAX)  retry = 1'b1;
          else begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end
        end else if (to_inc == TO_MAX) begin
          state_nxt = S_GAP;
          fin       = 1'b1;
          fin_err   = 1'b1;
        end
      end
      S_GAP: if (gap_cnt >= GAP_LAST && !tr_end)
        state_nxt = retry_pend ? S_ISSUE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i2c or posedge camera_rst) begin
    if (camera_rst) begin
      start      <= 1'b0;
      i2c_data   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy       <= 1'b0;
      retry_cnt  <= '0;
      to_cnt     <= '0;
      gap_cnt    <= '0;
      retry_pend <= 1'b0;
      mask       <= '0;
    end else begin
      done_q <= fin;
      err_q  <= fin_err;
      start  <= (state_nxt == S_ISSUE) || (state_nxt == S_WAIT_END);
      if (take) begin
        i2c_data  <= gnt_sel ? i2c_data1 : i2c_data0;
        busy      <= 1'b1;
        retry_cnt <= '0;
        mask      <= gnt_sel ? 2'b10 : 2'b01;
      end else if (done_q) begin
        mask <= '0;
      end
      if (state == S_ISSUE) begin
        to_cnt     <= '0;
        retry_pend <= 1'b0;
      end
      if (state == S_WAIT_END) begin
        to_cnt <= to_inc;
        if (retry) begin
          retry_cnt  <= retry_cnt + 1'b1;
          retry_pend <= 1'b1;
        end
      end
      if (state != S_GAP)         gap_cnt <= '0;
      else if (gap_cnt != 4'hf)   gap_cnt <= gap_cnt + 1'b1;
      if (state == S_GAP && state_nxt == S_IDLE) busy <= 1'b0;
    end
  end

  assign done0 = done_q & ~gnt_id;
  assign done1 = done_q &  gnt_id;
  assign err0  = err_q  & ~gnt_id;
  assign err1  = err_q  &  gnt_id;
endmodule
